// File: rtl/aon_csr_pkg.sv
// Shared types and helpers for the always-on APB CSR bank.
package aon_csr_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

   typedef enum logic [1:0] {RW, RO, W1C} reg_type_t;

   localparam int unsigned MAX_REGS = 64;
   localparam int unsigned CNT_W    = 4;

   function automatic int unsigned strb_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // RO wins over W1C when both mask bits are set.
   function automatic reg_type_t reg_type_of(input logic [MAX_REGS-1:0] ro_mask,
                                             input logic [MAX_REGS-1:0] w1c_mask,
                                             input logic [5:0]          idx);
      if (ro_mask[idx]) return RO;
      if (w1c_mask[idx]) return W1C;
      return RW;
   endfunction

endpackage

// File: rtl/aon_apb_slv_fsm.sv
// APB slave handshake: setup/access sequencing, wait-state counter and PREADY.
module aon_apb_slv_fsm
   import aon_csr_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic psel,
   input  logic penable,
   output logic ready,
   output logic complete
);

   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

   apb_state_t       state_q, state_d, phase;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // SETUP is recognised in the same cycle the bus presents it, so the access
   // phase is exactly WAIT_STATES+1 cycles and back-to-back setups need no idle gap.
   always_comb begin
      phase    = state_q;
      state_d  = IDLE;
      cnt_d    = '0;
      ready    = 1'b0;
      if (state_q == IDLE && psel && !penable) phase = SETUP;
      case (phase)
         IDLE:    state_d = IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS: begin
            ready = psel && penable && (cnt_q == WAIT_CNT);
            if (!psel || ready) begin
               state_d = IDLE;
            end else begin
               state_d = ACCESS;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign complete = ready;

endmodule

// File: rtl/aon_csr_bank.sv
// APB4 register bank for the always-on domain: RW, RO and W1C registers with irq.
module aon_csr_bank
   import aon_csr_pkg::*;
#(
   parameter int unsigned                         DATA_WIDTH  = 32,
   parameter int unsigned                         ADDR_WIDTH  = 32,
   parameter int unsigned                         NUM_REGS    = 8,
   parameter int unsigned                         WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]                 RO_MASK     = '0,
   parameter logic [NUM_REGS-1:0]                 W1C_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RESET_VAL   = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESETn,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
   output logic                           irq
);

   localparam int unsigned DW     = DATA_WIDTH;
   localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned NSLOT  = 2 ** IDX_W;

   logic                  ready, complete;
   logic [ADDR_WIDTH-3:0] addr_idx;
   logic [IDX_W-1:0]      idx_sel;
   logic                  in_range, err, wr_commit;
   logic [DW-1:0]         bmask, rd_val;
   logic [DW-1:0]         rd_arr [NSLOT];
   logic [NSLOT-1:0]      ro_flag;
   logic [NUM_REGS-1:0]   w1c_any;

   aon_apb_slv_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
      .clk      (PCLK),
      .rst_n    (PRESETn),
      .psel     (PSEL),
      .penable  (PENABLE),
      .ready    (ready),
      .complete (complete)
   );

   assign addr_idx  = PADDR[ADDR_WIDTH-1:2];
   assign idx_sel   = PADDR[IDX_W+1:2];
   assign in_range  = addr_idx < (ADDR_WIDTH-2)'(NUM_REGS);
   assign err       = (|PADDR[1:0]) || !in_range || (PWRITE && ro_flag[idx_sel]);
   assign wr_commit = complete && PWRITE && !err;

   always_comb begin
      bmask = '0;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         bmask[b*8 +: 8] = {8{PSTRB[b]}};
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      localparam reg_type_t     RT = reg_type_of(MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK), 6'(g));
      localparam logic [DW-1:0] RV = RESET_VAL[g*DW +: DW];

      logic [DW-1:0] q;
      logic          wr_hit;

      assign wr_hit = wr_commit && (idx_sel == IDX_W'(g));

      if (RT == RO) begin : g_ro
         logic unused_ro;
         assign q          = RV;
         assign rd_arr[g]  = hw_rdata[g*DW +: DW];
         assign ro_flag[g] = 1'b1;
         assign w1c_any[g] = 1'b0;
         assign unused_ro  = ^{hw_set[g*DW +: DW], wr_hit};
      end else if (RT == W1C) begin : g_w1c
         logic [DW-1:0] clr;
         logic          unused_w1c;
         assign clr = wr_hit ? (PWDATA & bmask) : '0;
         // Clear first, then OR in hw_set so a same-cycle set wins.
         always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) q <= RV;
            else          q <= (q & ~clr) | hw_set[g*DW +: DW];
         end
         assign rd_arr[g]  = q;
         assign ro_flag[g] = 1'b0;
         assign w1c_any[g] = |q;
         assign unused_w1c = ^hw_rdata[g*DW +: DW];
      end else begin : g_rw
         logic unused_rw;
         always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn)    q <= RV;
            else if (wr_hit) q <= (q & ~bmask) | (PWDATA & bmask);
         end
         assign rd_arr[g]  = q;
         assign ro_flag[g] = 1'b0;
         assign w1c_any[g] = 1'b0;
         assign unused_rw  = ^{hw_set[g*DW +: DW], hw_rdata[g*DW +: DW]};
      end

      assign reg_q[g*DW +: DW] = q;
   end

   // Slots past NUM_REGS exist only so idx_sel can index directly; they are never selected.
   for (genvar g = NUM_REGS; g < NSLOT; g++) begin : g_pad
      assign rd_arr[g]  = '0;
      assign ro_flag[g] = 1'b0;
   end

   assign rd_val  = rd_arr[idx_sel];
   assign PREADY  = ready;
   assign PSLVERR = ready && err;
   assign PRDATA  = (ready && !PWRITE && !err) ? rd_val : '0;
   assign irq     = |w1c_any;

endmodule

// File: tb/tb_aon_csr_bank.sv
// Directed bench for aon_csr_bank: vector table plus W1C, RO, abort and reset sequences.
module tb_aon_csr_bank;

   localparam logic [255:0] RV = {32'h0, 32'h0, 32'h0, 32'h0,
                                  32'hCAFE_0000, 32'h0, 32'h0000_00A5, 32'h0};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         psel, penable, pwrite;
   logic [31:0]  paddr, pwdata, prdata;
   logic [3:0]   pstrb;
   logic         pready, pslverr, irq;
   logic [255:0] reg_q, hw_rdata, hw_set;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aon_csr_bank #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .NUM_REGS    (8),
      .WAIT_STATES (3),
      .RO_MASK     (8'h08),
      .W1C_MASK    (8'h04),
      .RESET_VAL   (RV)
   ) dut (
      .PCLK     (clk),
      .PRESETn  (rst_n),
      .PSEL     (psel),
      .PENABLE  (penable),
      .PWRITE   (pwrite),
      .PADDR    (paddr),
      .PWDATA   (pwdata),
      .PSTRB    (pstrb),
      .PRDATA   (prdata),
      .PREADY   (pready),
      .PSLVERR  (pslverr),
      .reg_q    (reg_q),
      .hw_rdata (hw_rdata),
      .hw_set   (hw_set),
      .irq      (irq)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at #1 after a rising edge; returns at #1 after the commit edge.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit keep,
                       output logic [31:0] rd, output logic er, output int unsigned acc);
      bit done = 0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge clk) #1;
      penable = 1'b1;
      acc = 0; rd = '0; er = 1'b0;
      while (!done && acc < 20) begin
         acc++;
         if (pready) begin
            rd = prdata; er = pslverr; done = 1;
         end
         @(posedge clk) #1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL xfer_timeout: addr %h no PREADY within %0d cycles", addr, acc);
      end
      penable = 1'b0;
      if (!keep) psel = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0]  rd;
      logic         er;
      int unsigned  acc;

      vecs[0]  = '{0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_00A5, 0};
      vecs[1]  = '{1, 32'h0000_0000, 32'hDEAD_BEEF, 4'h5, 32'h0,         0};
      vecs[2]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h00AD_00EF, 0};
      vecs[3]  = '{1, 32'h0000_0000, 32'h1122_3344, 4'h0, 32'h0,         0};
      vecs[4]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h00AD_00EF, 0};
      vecs[5]  = '{1, 32'h0000_0000, 32'h1122_3344, 4'hA, 32'h0,         0};
      vecs[6]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h11AD_33EF, 0};
      vecs[7]  = '{0, 32'h0000_000C, 32'h0,         4'h0, 32'h0000_1234, 0};
      vecs[8]  = '{1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 32'h0,         1};
      vecs[9]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 32'h0,         1};
      vecs[10] = '{1, 32'h0000_0002, 32'h1234_5678, 4'hF, 32'h0,         1};
      vecs[11] = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h11AD_33EF, 0};
      vecs[12] = '{1, 32'h0000_001C, 32'hA5A5_A5A5, 4'hF, 32'h0,         0};
      vecs[13] = '{0, 32'h0000_001C, 32'h0,         4'h0, 32'hA5A5_A5A5, 0};
      vecs[14] = '{0, 32'h0000_0003, 32'h0,         4'h0, 32'h0,         1};
      vecs[15] = '{1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'h0,         1};

      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; hw_set = '0;
      hw_rdata = '0; hw_rdata[96 +: 32] = 32'h0000_1234;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready",  {31'd0, pready},  32'd0);
      chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
      chk("rst_prdata",  prdata,           32'd0);
      chk("rst_irq",     {31'd0, irq},     32'd0);
      chk("rst_reg0",    reg_q[0 +: 32],   32'h0);
      chk("rst_reg1",    reg_q[32 +: 32],  32'h0000_00A5);
      chk("rst_reg3",    reg_q[96 +: 32],  32'hCAFE_0000);
      rst_n = 1'b1;
      @(posedge clk) #1;

      for (int i = 0; i < 16; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, rd, er, acc);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_cycles", i), acc, 32'd4);
      end
      chk("tbl_reg0", reg_q[0 +: 32],   32'h11AD_33EF);
      chk("tbl_reg3", reg_q[96 +: 32],  32'hCAFE_0000);
      chk("tbl_reg7", reg_q[224 +: 32], 32'hA5A5_A5A5);

      // Back-to-back write then read with no idle cycle.
      xfer(1, 32'h18, 32'h55AA_55AA, 4'hF, 1, rd, er, acc);
      chk("b2b_wr_cycles", acc, 32'd4);
      xfer(0, 32'h18, 32'h0, 4'h0, 0, rd, er, acc);
      chk("b2b_rd_data", rd, 32'h55AA_55AA);
      chk("b2b_rd_cycles", acc, 32'd4);

      // W1C set latency, clear, and set-beats-clear.
      hw_set[64 +: 32] = 32'h11;
      chk("w1c_irq_latency", {31'd0, irq}, 32'd0);
      @(posedge clk) #1;
      hw_set = '0;
      chk("w1c_set_irq", {31'd0, irq}, 32'd1);
      chk("w1c_set_reg", reg_q[64 +: 32], 32'h11);
      xfer(1, 32'h8, 32'h01, 4'hF, 0, rd, er, acc);
      xfer(0, 32'h8, 32'h0, 4'h0, 0, rd, er, acc);
      chk("w1c_clr_read", rd, 32'h10);
      chk("w1c_clr_irq", {31'd0, irq}, 32'd1);
      hw_set[64 +: 32] = 32'h10;
      xfer(1, 32'h8, 32'h10, 4'hF, 0, rd, er, acc);
      hw_set = '0;
      chk("w1c_set_wins", reg_q[64 +: 32], 32'h10);
      xfer(1, 32'h8, 32'h10, 4'hF, 0, rd, er, acc);
      chk("w1c_final_reg", reg_q[64 +: 32], 32'h0);
      chk("w1c_final_irq", {31'd0, irq}, 32'd0);
      xfer(1, 32'h8, 32'h10, 4'hE, 0, rd, er, acc);

      // hw_set must not touch RW or RO registers.
      hw_set[160 +: 32] = 32'hFF; hw_set[96 +: 32] = 32'hFF;
      @(posedge clk) #1;
      hw_set = '0;
      chk("hwset_rw_ignored", reg_q[160 +: 32], 32'h0);
      chk("hwset_ro_ignored", reg_q[96 +: 32], 32'hCAFE_0000);

      // PSEL dropped mid-access: no commit, next transfer completes.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14;
      pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      @(posedge clk) #1; penable = 1'b1;
      @(posedge clk) #1; psel = 1'b0; penable = 1'b0;
      @(posedge clk) #1;
      chk("abort_no_commit", reg_q[160 +: 32], 32'h0);
      xfer(0, 32'h4, 32'h0, 4'h0, 0, rd, er, acc);
      chk("abort_next_rd", rd, 32'h0000_00A5);
      chk("abort_next_cycles", acc, 32'd4);

      // Reset during a write access phase.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0;
      pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      @(posedge clk) #1; penable = 1'b1;
      @(posedge clk) #1; rst_n = 1'b0;
      #1;
      chk("mid_rst_pready", {31'd0, pready}, 32'd0);
      chk("mid_rst_reg0", reg_q[0 +: 32], 32'h0);
      chk("mid_rst_reg1", reg_q[32 +: 32], 32'h0000_00A5);
      chk("mid_rst_reg7", reg_q[224 +: 32], 32'h0);
      chk("mid_rst_prdata", prdata, 32'h0);
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk) #1;
      chk("post_rst_reg0", reg_q[0 +: 32], 32'h0);
      xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, er, acc);
      chk("post_rst_rd0", rd, 32'h0);
      chk("post_rst_cycles", acc, 32'd4);
      xfer(1, 32'h0, 32'h0000_BEEF, 4'h3, 0, rd, er, acc);
      chk("post_rst_wr_err", {31'd0, er}, 32'd0);
      chk("post_rst_reg0_wr", reg_q[0 +: 32], 32'h0000_BEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
